score_counter_display: RTL and testbench

SCORE_COUNTER_DISPLAY -- requirements
Module: score_counter_display

---
 rtl/score_counter_display.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_score_counter_display.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_counter_display.sv
// -----------------------------------------------------------------------------
// score_counter_display
//
// Purpose: decimal (BCD) score counter with a seven-segment pixel renderer and
// a visibility FSM. After each point the digits blink for a few frames. Once
// the score saturates at MAX_SCORE the digits blink indefinitely.
//
// Ports:
//   clock      in   system clock, all state on the rising edge
//   reset      in   asynchronous, active-high reset
//   point      in   one-cycle pulse, add one to the score
//   clear      in   one-cycle pulse, score to zero (wins over point)
//   frameTick  in   one-cycle pulse, once per video frame
//   xPos       in   [11:0] current horizontal pixel
//   yPos       in   [11:0] current vertical pixel
//   drawScore  out  registered pixel-on for the score glyphs
//   scoreBcd   out  [4*DIGITS-1:0] packed BCD score, ones digit in [3:0]
//   atMax      out  high while the score equals MAX_SCORE
//
// Optional feature: define SCORE_LEADING_ZERO_BLANK_EN to blank zero digits
// that are more significant than the first nonzero digit. The ones digit is
// always drawn.
// -----------------------------------------------------------------------------
module score_counter_display #(
  parameter int DIGITS       = 2,
  parameter int LEFT         = 10,
  parameter int TOP          = 10,
  parameter int HEIGHT       = 50,
  parameter int DIGIT_W      = 25,
  parameter int GAP          = 10,
  parameter int MAX_SCORE    = 99,
  parameter int BLINK_FRAMES = 8,
  parameter int BLINK_COUNT  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  point,
  input  logic                  clear,
  input  logic                  frameTick,
  input  logic [11:0]           xPos,
  input  logic [11:0]           yPos,
  output logic                  drawScore,
  output logic [4*DIGITS-1:0]   scoreBcd,
  output logic                  atMax
);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [4*DIGITS-1:0] int_to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int                  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal increment with carry ripple from the ones digit upward.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Segment order {a,b,c,d,e,f,g}; non-BCD nibbles are blank.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [4*DIGITS-1:0] MAX_BCD = int_to_bcd(MAX_SCORE);

  localparam int FW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);
  localparam int PW = (BLINK_COUNT  < 2) ? 1 : $clog2(BLINK_COUNT  + 1);
  localparam logic [FW-1:0] FRAMES_LD = FW'(BLINK_FRAMES);
  localparam logic [PW-1:0] PAIRS_LD  = PW'(BLINK_COUNT);

  // Geometry in 13 bits so that right/bottom bounds never wrap.
  localparam logic [12:0] Y0    = 13'(TOP);
  localparam logic [12:0] Y1    = 13'(TOP + HEIGHT);
  localparam logic [12:0] A_END = 13'(HEIGHT / 5);
  localparam logic [12:0] D_BEG = 13'(HEIGHT - HEIGHT / 5);
  localparam logic [12:0] G_BEG = 13'(HEIGHT * 2 / 5);
  localparam logic [12:0] G_END = 13'(HEIGHT * 3 / 5);
  localparam logic [12:0] L_END = 13'(DIGIT_W / 3);
  localparam logic [12:0] R_BEG = 13'(DIGIT_W - DIGIT_W / 3);

  typedef enum logic [1:0] {
    SHOW      = 2'd0,
    BLINK_OFF = 2'd1,
    BLINK_ON  = 2'd2,
    WON       = 2'd3
  } vis_state_e;

  // ---------------------------------------------------------------------------
  // Score counter
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] score_q, score_d, score_inc;
  logic                atMax_q;
  logic                at_max, reach_max;

  assign score_inc = bcd_inc(score_q);
  assign at_max    = (score_q == MAX_BCD);
  assign reach_max = (score_inc == MAX_BCD);

  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (point && !at_max) begin
      score_d = score_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Visibility FSM
  // ---------------------------------------------------------------------------
  vis_state_e      state_q;
  logic [FW-1:0]   frame_q;
  logic [PW-1:0]   pair_q;
  logic            won_vis_q;
  logic            frame_last;
  logic            vis;

  // The tick that brings the counter to zero is the one that transitions.
  assign frame_last = (frame_q <= FW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SHOW;
      frame_q   <= '0;
      pair_q    <= '0;
      won_vis_q <= 1'b1;
    end else if (clear) begin
      state_q   <= SHOW;
      frame_q   <= '0;
      pair_q    <= '0;
      won_vis_q <= 1'b1;
    end else if (point) begin
      // A point always consumes a coincident frameTick. A point at the
      // saturation value changes nothing.
      if (!at_max) begin
        frame_q <= FRAMES_LD;
        if (reach_max) begin
          state_q   <= WON;
          won_vis_q <= 1'b1;
        end else begin
          state_q <= BLINK_OFF;
          pair_q  <= PAIRS_LD;
        end
      end
    end else if (frameTick) begin
      case (state_q)
        BLINK_OFF: begin
          if (frame_last) begin
            state_q <= BLINK_ON;
            frame_q <= FRAMES_LD;
          end else begin
            frame_q <= frame_q - FW'(1);
          end
        end
        BLINK_ON: begin
          if (frame_last) begin
            frame_q <= FRAMES_LD;
            if (pair_q <= PW'(1)) begin
              pair_q  <= '0;
              state_q <= SHOW;
            end else begin
              pair_q  <= pair_q - PW'(1);
              state_q <= BLINK_OFF;
            end
          end else begin
            frame_q <= frame_q - FW'(1);
          end
        end
        WON: begin
          if (frame_last) begin
            frame_q   <= FRAMES_LD;
            won_vis_q <= ~won_vis_q;
          end else begin
            frame_q <= frame_q - FW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign vis = (state_q != BLINK_OFF) && !((state_q == WON) && !won_vis_q);

  // ---------------------------------------------------------------------------
  // Glyph renderer
  // ---------------------------------------------------------------------------
  logic [12:0]       x13, y13, ly;
  logic              in_y;
  logic [DIGITS-1:0] pix;
  logic              draw_d;

  assign x13  = {1'b0, xPos};
  assign y13  = {1'b0, yPos};
  assign in_y = (y13 >= Y0) && (y13 < Y1);
  assign ly   = y13 - Y0;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    // Digit k = 0 is the most significant and sits leftmost.
    localparam int          SH = 4 * (DIGITS - 1 - k);
    localparam logic [12:0] X0 = 13'(LEFT + k * (DIGIT_W + GAP));
    localparam logic [12:0] X1 = 13'(LEFT + k * (DIGIT_W + GAP) + DIGIT_W);

    logic [3:0]  nib;
    logic [12:0] lx;
    logic        in_box;
    logic [6:0]  band;
    logic        show;

    assign nib    = score_q[SH +: 4];
    assign lx     = x13 - X0;
    assign in_box = in_y && (x13 >= X0) && (x13 < X1);

    assign band[6] = (ly < A_END);                        // a
    assign band[5] = (lx >= R_BEG) && (ly < G_END);       // b
    assign band[4] = (lx >= R_BEG) && (ly >= G_BEG);      // c
    assign band[3] = (ly >= D_BEG);                       // d
    assign band[2] = (lx < L_END) && (ly >= G_BEG);       // e
    assign band[1] = (lx < L_END) && (ly < G_END);        // f
    assign band[0] = (ly >= G_BEG) && (ly < G_END);       // g

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more significant digit are zero.
    if (k == DIGITS - 1) begin : g_ones
      assign show = 1'b1;
    end else begin : g_upper
      assign show = (score_q[4*DIGITS-1 : SH] != '0);
    end
`else
    assign show = 1'b1;
`endif

    assign pix[k] = in_box && show && (|(seg7(nib) & band));
  end

  assign draw_d = vis && (|pix);

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic drawScore_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      score_q     <= '0;
      atMax_q     <= 1'b0;
      drawScore_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      atMax_q     <= (score_d == MAX_BCD);
      drawScore_q <= draw_d;
    end
  end

  assign scoreBcd  = score_q;
  assign atMax     = atMax_q;
  assign drawScore = drawScore_q;

endmodule

// File: tb/tb_score_counter_display.sv
module tb_score_counter_display;

  localparam int DIGITS = 2;
  localparam int LEFT   = 10;
  localparam int TOP    = 10;
  localparam int H      = 50;
  localparam int W      = 25;
  localparam int GAP    = 10;
  localparam int MAXS   = 99;
  localparam int BF     = 2;
  localparam int BC     = 1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  // Probe on segment a of the ones digit
  localparam int PX_ONES = LEFT + W + GAP + 1;
  localparam int PY_A    = TOP + 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                point, clear, frameTick;
  logic [11:0]         xPos, yPos;
  logic                drawScore;
  logic [4*DIGITS-1:0] scoreBcd;
  logic                atMax;

  score_counter_display #(
    .DIGITS(DIGITS), .LEFT(LEFT), .TOP(TOP), .HEIGHT(H), .DIGIT_W(W),
    .GAP(GAP), .MAX_SCORE(MAXS), .BLINK_FRAMES(BF), .BLINK_COUNT(BC)
  ) dut (
    .clock(clock), .reset(reset), .point(point), .clear(clear),
    .frameTick(frameTick), .xPos(xPos), .yPos(yPos),
    .drawScore(drawScore), .scoreBcd(scoreBcd), .atMax(atMax)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: score as an integer; mode 0 = steady, 1 = blinking
  // after a point, 2 = won; ticks = frames counted since the mode began.
  int m_score, m_mode, m_ticks;
  logic [4*DIGITS-1:0] exp_bcd;
  logic                exp_max, exp_draw;

  string SEGS [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_seg(input int d, input byte c);
    string s;
    s = SEGS[d];
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_vis();
    if (m_mode == 1) return ((m_ticks / BF) % 2) == 1;
    if (m_mode == 2) return ((m_ticks / BF) % 2) == 0;
    return 1'b1;
  endfunction

  function automatic bit model_pix(input int sc, input int x, input int y, input bit v);
    int pitch, k, lx, ly, p10, dg;
    bit on;
    if (!v) return 1'b0;
    if (y < TOP || y >= TOP + H || x < LEFT) return 1'b0;
    pitch = W + GAP;
    k  = (x - LEFT) / pitch;
    lx = (x - LEFT) % pitch;
    if (k >= DIGITS || lx >= W) return 1'b0;
    p10 = 1;
    for (int i = 0; i < DIGITS - 1 - k; i++) p10 = p10 * 10;
    dg = (sc / p10) % 10;
    if (LZ_EN && k < DIGITS - 1 && sc < p10) return 1'b0;
    ly = y - TOP;
    on = 1'b0;
    if (has_seg(dg, "a") && ly < H / 5) on = 1'b1;
    if (has_seg(dg, "d") && ly >= H - H / 5) on = 1'b1;
    if (has_seg(dg, "g") && ly >= H * 2 / 5 && ly < H * 3 / 5) on = 1'b1;
    if (has_seg(dg, "f") && lx < W / 3 && ly < H * 3 / 5) on = 1'b1;
    if (has_seg(dg, "b") && lx >= W - W / 3 && ly < H * 3 / 5) on = 1'b1;
    if (has_seg(dg, "e") && lx < W / 3 && ly >= H * 2 / 5) on = 1'b1;
    if (has_seg(dg, "c") && lx >= W - W / 3 && ly >= H * 2 / 5) on = 1'b1;
    return on;
  endfunction

  task automatic model_reset();
    m_score = 0; m_mode = 0; m_ticks = 0;
    exp_bcd = '0; exp_max = 1'b0; exp_draw = 1'b0;
  endtask

  // Drive one clock cycle of stimulus and advance the reference model.
  task automatic drive_cycle(input bit p, input bit c, input bit t, input int x, input int y);
    point = p; clear = c; frameTick = t;
    xPos = 12'(x); yPos = 12'(y);
    exp_draw = model_pix(m_score, x, y, model_vis());
    @(posedge clock);
    #1;
    if (c) begin
      m_score = 0; m_mode = 0; m_ticks = 0;
    end else if (p) begin
      if (m_score < MAXS) begin
        m_score++;
        m_mode  = (m_score == MAXS) ? 2 : 1;
        m_ticks = 0;
      end
    end else if (t && m_mode != 0) begin
      m_ticks++;
      if (m_mode == 1 && m_ticks >= 2 * BF * BC) begin
        m_mode = 0; m_ticks = 0;
      end
    end
    exp_bcd = to_bcd(m_score);
    exp_max = (m_score == MAXS);
    point = 1'b0; clear = 1'b0; frameTick = 1'b0;
  endtask

  task automatic test_reset();
    point = 0; clear = 0; frameTick = 0; xPos = '0; yPos = '0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #2;
    model_reset();
    n_tests++;
    if (scoreBcd !== '0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 0", scoreBcd); end
    n_tests++;
    if (atMax !== 1'b0) begin n_fail++; $display("FAIL reset_atmax: got %b expected 0", atMax); end
    n_tests++;
    if (drawScore !== 1'b0) begin n_fail++; $display("FAIL reset_draw: got %b expected 0", drawScore); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_count12();
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_tests++;
      if (scoreBcd !== exp_bcd) begin n_fail++; $display("FAIL count_step: got %h expected %h", scoreBcd, exp_bcd); end
    end
    n_tests++;
    if (scoreBcd !== 8'h12) begin n_fail++; $display("FAIL count12_bcd: got %h expected 12", scoreBcd); end
    n_tests++;
    if (atMax !== 1'b0) begin n_fail++; $display("FAIL count12_atmax: got %b expected 0", atMax); end
  endtask

  task automatic test_saturate();
    drive_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 98; i++) drive_cycle(1, 0, 0, 0, 0);
    n_tests++;
    if (scoreBcd !== 8'h98 || atMax !== 1'b0) begin
      n_fail++; $display("FAIL sat_98: got %h/%b expected 98/0", scoreBcd, atMax);
    end
    drive_cycle(1, 0, 0, 0, 0);
    n_tests++;
    if (scoreBcd !== 8'h99 || atMax !== 1'b1) begin
      n_fail++; $display("FAIL sat_99: got %h/%b expected 99/1", scoreBcd, atMax);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 0, 0, 0, 0);
      n_tests++;
      if (scoreBcd !== 8'h99 || atMax !== 1'b1) begin
        n_fail++; $display("FAIL sat_hold: got %h/%b expected 99/1", scoreBcd, atMax);
      end
    end
    // Won: visibility toggles every BF frames, indefinitely
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 0, 1, PX_ONES, PY_A);
      n_tests++;
      if (drawScore !== exp_draw) begin
        n_fail++; $display("FAIL won_blink[%0d]: got %b expected %b", i, drawScore, exp_draw);
      end
    end
  endtask

  task automatic test_clear_priority();
    drive_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle(1, 0, 0, 0, 0);
    n_tests++;
    if (scoreBcd !== 8'h05) begin n_fail++; $display("FAIL clr_pre: got %h expected 05", scoreBcd); end
    drive_cycle(1, 1, 0, PX_ONES, PY_A);
    n_tests++;
    if (scoreBcd !== 8'h00 || atMax !== 1'b0) begin
      n_fail++; $display("FAIL clr_win: got %h/%b expected 00/0", scoreBcd, atMax);
    end
    // Steady display: no blink phase follows
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, 1, PX_ONES, PY_A);
      n_tests++;
      if (drawScore !== 1'b1) begin n_fail++; $display("FAIL clr_show[%0d]: got %b expected 1", i, drawScore); end
    end
  endtask

  task automatic test_blink();
    bit want [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(0, 0, 1, PX_ONES, PY_A);
      n_tests++;
      if (drawScore !== want[i] || drawScore !== exp_draw) begin
        n_fail++; $display("FAIL blink_tick[%0d]: got %b expected %b", i, drawScore, want[i]);
      end
    end
  endtask

  task automatic test_leading_zero();
    drive_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(0, 0, 0, LEFT + 1, TOP + 1);
    n_tests++;
    if (drawScore !== !LZ_EN) begin
      n_fail++; $display("FAIL lead_zero: got %b expected %b", drawScore, !LZ_EN);
    end
    drive_cycle(0, 0, 0, LEFT + W + GAP + W - 1, TOP + 1);
    n_tests++;
    if (drawScore !== 1'b1) begin n_fail++; $display("FAIL ones_seven_b: got %b expected 1", drawScore); end
  endtask

  task automatic test_reset_midblink();
    drive_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(0, 0, 1, PX_ONES, PY_A);
    reset = 1'b1;
    #2;
    model_reset();
    n_tests++;
    if (scoreBcd !== '0 || atMax !== 1'b0 || drawScore !== 1'b0) begin
      n_fail++; $display("FAIL midblink_reset: got %h/%b/%b expected 00/0/0", scoreBcd, atMax, drawScore);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 0, 1, PX_ONES, PY_A);
      n_tests++;
      if (drawScore !== 1'b1) begin n_fail++; $display("FAIL midblink_after[%0d]: got %b expected 1", i, drawScore); end
    end
  endtask

  task automatic test_random();
    bit p, c, t;
    int x, y;
    drive_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 599) == 0);
      t = ($urandom_range(0, 2) == 0);
      x = $urandom_range(LEFT - 3, LEFT + 2 * (W + GAP) + 3);
      y = $urandom_range(TOP - 3, TOP + H + 3);
      drive_cycle(p, c, t, x, y);
      n_tests++;
      if (scoreBcd !== exp_bcd) begin n_fail++; $display("FAIL rnd_bcd[%0d]: got %h expected %h", i, scoreBcd, exp_bcd); end
      n_tests++;
      if (atMax !== exp_max) begin n_fail++; $display("FAIL rnd_atmax[%0d]: got %b expected %b", i, atMax, exp_max); end
      n_tests++;
      if (drawScore !== exp_draw) begin
        n_fail++; $display("FAIL rnd_draw[%0d]: got %b expected %b at (%0d,%0d)", i, drawScore, exp_draw, x, y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count12();
    test_saturate();
    test_clear_priority();
    test_blink();
    test_leading_zero();
    test_reset_midblink();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
